// File: rtl/ucaspian_pkg.sv
// ucaspian_pkg: shared run-controller state type, metric address type and decode helper.
package ucaspian_pkg;

    typedef enum logic [1:0] {
        RS_IDLE    = 2'd0,
        RS_ADVANCE = 2'd1,
        RS_SETTLE  = 2'd2
    } run_state_t;

    typedef logic [7:0] metric_addr_t;

    localparam int METRIC_BYTES = 4;

    // Address 0 is reserved; counter m occupies nb consecutive bytes starting at 1+m*nb.
    function automatic logic metric_hit(metric_addr_t a, int m, int nb);
        return (int'(a) >= 1 + m * nb) && (int'(a) < 1 + (m + 1) * nb);
    endfunction

endpackage

// File: rtl/ucaspian_metric_ctr.sv
// ucaspian_metric_ctr: saturating metric counter with clear, read-clear and MSB-first byte select.
module ucaspian_metric_ctr #(
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_inc,
    input  logic       i_rd_clr,
    input  logic       i_hit,
    input  logic [7:0] i_sel,
    output logic [7:0] o_byte
);

    localparam int NB = W / 8;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset | i_clear | i_rd_clr)
            r_cnt <= '0;
        else if (i_inc & ~&r_cnt)
            r_cnt <= r_cnt + W'(1);
    end

    assign o_byte = i_hit ? 8'(r_cnt >> (8 * (NB - 1 - int'(i_sel)))) : 8'h00;

endmodule

// File: rtl/ucaspian_run_ctrl.sv
// ucaspian_run_ctrl: network time-step controller (target tracking, free-run/single-step)
// plus saturating read-and-clear metric counters.
module ucaspian_run_ctrl
    import ucaspian_pkg::*;
#(
    parameter int TIME_W      = 32,
    parameter int NUM_UNITS   = 5,
    parameter int NUM_METRICS = 3,
    parameter int METRIC_W    = 8 * METRIC_BYTES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [NUM_UNITS-1:0]   unit_step_done,
    input  logic                   output_pending,
    input  logic                   input_pending,
    input  logic [7:0]             target_value,
    input  logic                   target_valid,
    output logic                   target_ack,
    input  logic                   single_step,
    input  logic                   step_req,
    output logic                   next_step,
    output logic [TIME_W-1:0]      time_current,
    output logic                   time_remaining,
    output logic                   time_update,
    input  logic                   time_sent,
    output logic                   core_active,
    input  logic [NUM_METRICS-1:0] metric_inc,
    input  logic [7:0]             metric_addr,
    input  logic                   metric_read,
    output logic [7:0]             metric_value,
    output logic                   metric_send
);

    localparam int MB = METRIC_W / 8;
    localparam int NC = NUM_METRICS + 1;

    run_state_t        r_state;
    logic              r_done_q;
    logic [TIME_W-1:0] r_time;
    logic [TIME_W-1:0] r_target;
    logic              r_remaining;
    logic              r_update;
    logic              r_token;
    logic              r_ack;
    logic [1:0]        r_active_q;
    logic [7:0]        r_value;
    logic              r_send;
    logic [NC-1:0]     r_rdclr;

    logic              w_clr;
    logic              w_done_all;
    logic              w_go;
    logic [TIME_W:0]   w_sum;
    logic [NC-1:0]     w_inc;
    logic [NC-1:0]     w_hit;
    logic [NC-1:0]     w_last;
    logic [7:0]        w_sel  [NC];
    logic [7:0]        w_byte [NC];
    logic [7:0]        w_rd;

    assign w_clr      = reset | clear;
    assign w_done_all = &unit_step_done & ~output_pending;
    // Both the live and the registered done must hold, so a unit glitching done for one cycle cannot advance time.
    assign w_go       = (r_state == RS_IDLE) & w_done_all & r_done_q & r_remaining & (~single_step | r_token);
    assign w_sum      = {1'b0, r_target} + (TIME_W + 1)'(target_value);

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state     <= RS_IDLE;
            r_done_q    <= 1'b0;
            r_time      <= '0;
            r_target    <= '0;
            r_remaining <= 1'b0;
            r_update    <= 1'b0;
            r_token     <= 1'b0;
            r_ack       <= 1'b0;
            r_active_q  <= '0;
        end else begin
            r_state     <= w_go ? RS_ADVANCE : (r_state == RS_ADVANCE) ? RS_SETTLE : RS_IDLE;
            r_done_q    <= w_done_all;
            r_time      <= r_time + TIME_W'(w_go);
            r_remaining <= r_target > r_time;
            r_update    <= (r_state == RS_ADVANCE) | (r_update & ~time_sent);
            r_token     <= single_step & (r_state != RS_ADVANCE) & (r_token | step_req);
            r_ack       <= target_valid & ~r_ack;
            r_active_q  <= {r_active_q[0], core_active};
            if (target_valid & ~r_ack)
                r_target <= w_sum[TIME_W] ? '1 : w_sum[TIME_W-1:0];
        end
    end

    assign next_step      = (r_state == RS_ADVANCE) & ~w_clr;
    assign time_current   = r_time;
    assign time_remaining = r_remaining;
    assign time_update    = r_update;
    assign target_ack     = r_ack;
    assign core_active    = ~reset & ~clear & (r_remaining | ~r_done_q | input_pending);

    // The active-cycle counter keeps counting for two cycles after activity drops to cover pipeline drain.
    assign w_inc = {core_active | (|r_active_q), metric_inc};

    for (genvar m = 0; m < NC; m++) begin : g_ctr
        assign w_hit[m]  = metric_hit(metric_addr, m, MB);
        assign w_sel[m]  = metric_addr - 8'(1 + m * MB);
        assign w_last[m] = metric_read & w_hit[m] & (w_sel[m] == 8'(MB - 1));
        ucaspian_metric_ctr #(.W(METRIC_W)) u_ctr (
            .clk      (clk),
            .reset    (reset),
            .i_clear  (clear),
            .i_inc    (w_inc[m]),
            .i_rd_clr (r_rdclr[m]),
            .i_hit    (w_hit[m]),
            .i_sel    (w_sel[m]),
            .o_byte   (w_byte[m])
        );
    end

    always_comb begin
        w_rd = 8'h00;
        for (int i = 0; i < NC; i++)
            w_rd = w_rd | w_byte[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= 8'h00;
            r_send  <= 1'b0;
            r_rdclr <= '0;
        end else begin
            r_send  <= metric_read;
            r_rdclr <= w_last;
            if (metric_read)
                r_value <= w_rd;
        end
    end

    assign metric_value = r_value;
    assign metric_send  = r_send & metric_read;

endmodule

// File: tb/tb_ucaspian_run_ctrl.sv
// tb_ucaspian_run_ctrl: directed checks of time advance, single-step, target saturation,
// clear behaviour and metric read-and-clear on an 8-bit-time instance.
module tb_ucaspian_run_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [4:0] unit_step_done = '0;
    logic       output_pending = 1'b0;
    logic       input_pending = 1'b0;
    logic [7:0] target_value = '0;
    logic       target_valid = 1'b0;
    logic       target_ack;
    logic       single_step = 1'b0;
    logic       step_req = 1'b0;
    logic       next_step;
    logic [7:0] time_current;
    logic       time_remaining;
    logic       time_update;
    logic       time_sent = 1'b0;
    logic       core_active;
    logic [2:0] metric_inc = '0;
    logic [7:0] metric_addr = '0;
    logic       metric_read = 1'b0;
    logic [7:0] metric_value;
    logic       metric_send;

    int errors = 0;
    int checks = 0;
    int n_steps = 0;
    int last_t = 0;
    int cyc = 0;
    int last_cyc = -1000;
    int min_gap = 1000;

    always #5 clk = ~clk;

    ucaspian_run_ctrl #(.TIME_W(8), .NUM_UNITS(5), .NUM_METRICS(3), .METRIC_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .unit_step_done (unit_step_done),
        .output_pending (output_pending),
        .input_pending  (input_pending),
        .target_value   (target_value),
        .target_valid   (target_valid),
        .target_ack     (target_ack),
        .single_step    (single_step),
        .step_req       (step_req),
        .next_step      (next_step),
        .time_current   (time_current),
        .time_remaining (time_remaining),
        .time_update    (time_update),
        .time_sent      (time_sent),
        .core_active    (core_active),
        .metric_inc     (metric_inc),
        .metric_addr    (metric_addr),
        .metric_read    (metric_read),
        .metric_value   (metric_value),
        .metric_send    (metric_send)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (next_step) begin
            n_steps  <= n_steps + 1;
            last_t   <= int'(time_current);
            last_cyc <= cyc;
            if (cyc - last_cyc < min_gap)
                min_gap <= cyc - last_cyc;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic add_target(input logic [7:0] v);
        target_value = v;
        target_valid = 1'b1;
        step();
        chk("target_ack_pulse", 32'(target_ack), 1);
        target_valid = 1'b0;
        step();
    endtask

    initial begin
        int b;
        logic found;
        logic [7:0] exp1 [4];
        exp1[0] = 8'h00; exp1[1] = 8'h00; exp1[2] = 8'h01; exp1[3] = 8'h2C;

        step(3);
        chk("rst_time", 32'(time_current), 0);
        chk("rst_next_step", 32'(next_step), 0);
        chk("rst_ack", 32'(target_ack), 0);
        chk("rst_remaining", 32'(time_remaining), 0);
        chk("rst_update", 32'(time_update), 0);
        chk("rst_core_active", 32'(core_active), 0);
        chk("rst_send", 32'(metric_send), 0);
        chk("rst_value", 32'(metric_value), 0);
        reset = 1'b0;
        unit_step_done = 5'h1F;
        step(3);
        chk("idle_core_active", 32'(core_active), 0);

        // free-run to target 5
        add_target(8'd5);
        step(30);
        chk("fr_steps", 32'(n_steps), 5);
        chk("fr_time", 32'(time_current), 5);
        chk("fr_last_t", 32'(last_t), 5);
        chk("fr_remaining", 32'(time_remaining), 0);
        chk("fr_update", 32'(time_update), 1);
        input_pending = 1'b1;
        #1;
        chk("input_active", 32'(core_active), 1);
        input_pending = 1'b0;
        time_sent = 1'b1;
        step();
        time_sent = 1'b0;
        chk("update_cleared", 32'(time_update), 0);

        // single-step: back-to-back requests give one advance
        single_step = 1'b1;
        add_target(8'd5);
        step(10);
        chk("ss_no_token", 32'(time_current), 5);
        b = n_steps;
        step_req = 1'b1;
        step(2);
        step_req = 1'b0;
        step(10);
        chk("ss_one_adv", 32'(n_steps - b), 1);
        chk("ss_time6", 32'(time_current), 6);
        step_req = 1'b1;
        step();
        step_req = 1'b0;
        step(10);
        chk("ss_time7", 32'(time_current), 7);

        // held target_valid is accepted every other cycle: target 10 -> 12
        target_value = 8'd1;
        target_valid = 1'b1;
        step();
        chk("ack_hold_1", 32'(target_ack), 1);
        step();
        chk("ack_hold_0", 32'(target_ack), 0);
        step(2);
        target_valid = 1'b0;
        step();

        // a unit not done, then output pending, blocks advance
        unit_step_done = 5'h1B;
        single_step = 1'b0;
        step(20);
        chk("unit_blocked", 32'(time_current), 7);
        unit_step_done = 5'h1F;
        step();
        chk("done_lat_1", 32'(next_step), 0);
        step();
        chk("done_lat_2", 32'(next_step), 1);
        chk("post_inc_time", 32'(time_current), 8);
        output_pending = 1'b1;
        step(10);
        chk("outpend_blocked", 32'(time_current), 8);
        chk("outpend_active", 32'(core_active), 1);
        output_pending = 1'b0;
        step(30);
        chk("resume_time", 32'(time_current), 12);
        chk("resume_remaining", 32'(time_remaining), 0);

        // target saturation at 255
        add_target(8'd238);
        add_target(8'd10);
        step(800);
        chk("sat_time", 32'(time_current), 255);
        chk("sat_remaining", 32'(time_remaining), 0);
        chk("min_gap", 32'(min_gap), 3);
        b = n_steps;
        add_target(8'd1);
        step(10);
        chk("sat_no_adv", 32'(n_steps - b), 0);
        chk("sat_time_hold", 32'(time_current), 255);

        // clear, then clear during an ADVANCE cycle
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_time", 32'(time_current), 0);
        chk("clr_update", 32'(time_update), 0);
        metric_inc = 3'b001;
        step(3);
        metric_inc = 3'b000;
        add_target(8'd20);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (next_step) found = 1'b1;
        end
        chk("adv_seen", 32'(found), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clradv_time", 32'(time_current), 0);
        chk("clradv_next", 32'(next_step), 0);
        b = n_steps;
        step(20);
        chk("clradv_no_adv", 32'(n_steps - b), 0);
        chk("clradv_remaining", 32'(time_remaining), 0);
        metric_addr = 8'd4;
        metric_read = 1'b1;
        step();
        chk("clr_ctr0", 32'(metric_value), 0);
        chk("clr_ctr0_send", 32'(metric_send), 1);
        metric_read = 1'b0;
        add_target(8'd2);
        step(20);
        chk("after_clr_time", 32'(time_current), 2);

        // 300 increments of counter 1, read-and-clear
        metric_inc = 3'b010;
        step(300);
        metric_inc = 3'b000;
        metric_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            metric_addr = 8'(5 + i);
            step();
            chk("ctr1_byte", 32'(metric_value), 32'(exp1[i]));
        end
        metric_addr = 8'd200;
        step();
        chk("bad_addr", 32'(metric_value), 0);
        for (int i = 0; i < 4; i++) begin
            metric_addr = 8'(5 + i);
            step();
            chk("ctr1_cleared", 32'(metric_value), 0);
        end
        metric_read = 1'b0;
        #1;
        chk("send_drop", 32'(metric_send), 0);

        // active-cycle counter: 4 active cycles + 2 trailing
        metric_addr = 8'd16;
        metric_read = 1'b1;
        step();
        metric_read = 1'b0;
        step(3);
        input_pending = 1'b1;
        step(4);
        input_pending = 1'b0;
        step(5);
        metric_read = 1'b1;
        step();
        chk("active_ctr", 32'(metric_value), 6);
        metric_read = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
